// File: rtl/ysyx_22040895_wb_arbiter_if.sv
// Bus bundle between the three writeback sources, the regfile write port and decode hazard logic.
// The arbiter sits on the slave modport; the sources, regfile and decode side share the master modport.
interface ysyx_22040895_wb_arbiter_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic                flush_i;
  logic [2:0]          req_valid_i;
  logic [2:0]          req_ready_o;
  logic [3*AW-1:0]     req_waddr_i;
  logic [3*XLEN-1:0]   req_wdata_i;
  logic                we_o;
  logic [AW-1:0]       waddr_o;
  logic [XLEN-1:0]     wdata_o;
  logic [AW-1:0]       raddr1_i;
  logic [AW-1:0]       raddr2_i;
  logic                pend_hit1_o;
  logic                pend_hit2_o;
  logic [2:0]          urgent_o;

  modport slave (
    input  flush_i, req_valid_i, req_waddr_i, req_wdata_i, raddr1_i, raddr2_i,
    output req_ready_o, we_o, waddr_o, wdata_o, pend_hit1_o, pend_hit2_o, urgent_o
  );

  modport master (
    output flush_i, req_valid_i, req_waddr_i, req_wdata_i, raddr1_i, raddr2_i,
    input  req_ready_o, we_o, waddr_o, wdata_o, pend_hit1_o, pend_hit2_o, urgent_o
  );
endinterface

// File: rtl/ysyx_22040895_wb_arbiter.sv
// Round-robin arbiter with a starvation guard that shares one regfile write port among EXU/LSU/CSR.
// The winning write is registered and drives the port one cycle later; pend_hit flags feed decode.
module ysyx_22040895_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 7
) (
  input  logic clk,
  input  logic rst,
  ysyx_22040895_wb_arbiter_if.slave bus
);

  localparam int         NSRC     = 3;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    SRC_EXU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_CSR = 2'd2
  } src_e;

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_EXU: return SRC_LSU;
      SRC_LSU: return SRC_CSR;
      default: return SRC_EXU;
    endcase
  endfunction

  src_e              rr_ptr_q, rr_ptr_d;
  logic [3:0]        wait_cnt_q [NSRC];
  logic [3:0]        wait_cnt_d [NSRC];
  logic [NSRC-1:0]   urgent_q, urgent_d;
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  src_e              cand [NSRC];
  logic [NSRC-1:0]   urgent_valid;
  logic [NSRC-1:0]   grant;
  logic              grant_any;
  src_e              grant_src;
  logic [AW-1:0]     sel_waddr;
  logic [XLEN-1:0]   sel_wdata;

  // Grant selection: urgent sources first (lowest index), else scan from rr_ptr.
  // NOTE: every variable in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    cand[0]      = rr_ptr_q;
    cand[1]      = next_src(rr_ptr_q);
    cand[2]      = next_src(cand[1]);
    urgent_valid = urgent_q & bus.req_valid_i;
    grant_any    = 1'b0;
    grant_src    = SRC_EXU;
    grant        = '0;

    if (rst) begin
      if (|urgent_valid) begin
        grant_any = 1'b1;
        if (urgent_valid[0])      grant_src = SRC_EXU;
        else if (urgent_valid[1]) grant_src = SRC_LSU;
        else                      grant_src = SRC_CSR;
      end else begin
        // Walk the scan order backwards so the earliest valid candidate wins.
        for (int k = NSRC - 1; k >= 0; k--) begin
          if (bus.req_valid_i[cand[k]]) begin
            grant_any = 1'b1;
            grant_src = cand[k];
          end
        end
      end
    end

    if (grant_any) grant[grant_src] = 1'b1;
  end

  always_comb begin
    sel_waddr = bus.req_waddr_i[int'(grant_src)*AW +: AW];
    sel_wdata = bus.req_wdata_i[int'(grant_src)*XLEN +: XLEN];

    rr_ptr_d = grant_any ? next_src(grant_src) : rr_ptr_q;

    for (int i = 0; i < NSRC; i++) begin
      if (bus.req_valid_i[i] && !grant[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q[i] + 4'd1;
      end else begin
        wait_cnt_d[i] = 4'd0;
      end
      urgent_d[i] = (wait_cnt_d[i] == WAIT_MAX);
    end

    // x0 and flushed writes are still accepted from the source; only the enable is dropped.
    we_d    = grant_any && !bus.flush_i && (sel_waddr != '0);
    waddr_d = grant_any ? sel_waddr : waddr_q;
    wdata_d = grant_any ? sel_wdata : wdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= SRC_EXU;
      urgent_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      // NOTE: the wait counters are an array but must be reset, since urgent_o is derived from them.
      for (int i = 0; i < NSRC; i++) wait_cnt_q[i] <= 4'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      urgent_q <= urgent_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < NSRC; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.urgent_o    = urgent_q;
  assign bus.we_o        = we_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.pend_hit1_o = we_q && (waddr_q == bus.raddr1_i) && (bus.raddr1_i != '0);
  assign bus.pend_hit2_o = we_q && (waddr_q == bus.raddr2_i) && (bus.raddr2_i != '0);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.req_ready_o));
  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst)
    (bus.req_ready_o & ~bus.req_valid_i) == '0);

endmodule
